// File: rtl/detseq_ctrl.sv
// -----------------------------------------------------------------------------
// detseq_ctrl
// Sequencing controller for a single-bit Mealy sequence detector. An accepted
// start captures a parallel word and pulses the detector reset for one cycle.
// The word is then streamed MSB-first into the detector, one bit per clock.
// The controller counts detector hits, with saturation, and records the bit
// index of the first hit. A one-cycle done pulse closes the run.
//
// Parameters
//   W   bits streamed per run (>= 2)
//   CW  hit-counter width
//   PW  first-hit index width, 2**PW > W so that W itself means "no hit"
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      run request, only looked at in IDLE
//   din        word captured on an accepted start
//   det_op     detector output (combinational in det_ip)
//   det_rst    detector reset: rst OR one-cycle clear pulse
//   det_ip     detector serial input, 0 outside SHIFT
//   busy       high during CLR and SHIFT
//   done       one-cycle pulse in DONE
//   hits       saturating hit count of the last run
//   first_pos  index (0 = MSB) of the first hit in the last run, W if none
// -----------------------------------------------------------------------------
module detseq_ctrl #(
    parameter int W  = 16,
    parameter int CW = 5,
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  din,
    input  logic          det_op,
    output logic          det_rst,
    output logic          det_ip,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] hits,
    output logic [PW-1:0] first_pos
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLR   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PW-1:0] NO_HIT = PW'(W);
    localparam logic [PW-1:0] LAST_K = PW'(W - 1);
    localparam logic [CW-1:0] HITS_MAX = {CW{1'b1}};

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic [PW-1:0] k_q, k_d;
    logic [CW-1:0] hits_q, hits_d;
    logic [PW-1:0] first_q, first_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        k_d     = k_q;
        hits_d  = hits_q;
        first_d = first_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    sreg_d  = din;
                    k_d     = '0;
                    hits_d  = '0;
                    first_d = NO_HIT;
                end
            end
            S_CLR: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // The streamed bit always sits at the MSB of the shift register.
                sreg_d = {sreg_q[W-2:0], 1'b0};
                k_d    = k_q + 1'b1;
                if (det_op) begin
                    if (hits_q != HITS_MAX) begin
                        hits_d = hits_q + 1'b1;
                    end
                    if (first_q == NO_HIT) begin
                        first_d = k_q;
                    end
                end
                if (k_q == LAST_K) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up with state_q.
    always_comb begin
        busy_d = (state_d == S_CLR) || (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            k_q     <= '0;
            hits_q  <= '0;
            first_q <= NO_HIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            k_q     <= k_d;
            hits_q  <= hits_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The detector reset follows rst asynchronously, so it is not registered.
    assign det_rst   = rst | (state_q == S_CLR);
    assign det_ip    = (state_q == S_SHIFT) & sreg_q[W-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign hits      = hits_q;
    assign first_pos = first_q;

endmodule
